// File: rtl/button_pulse_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : button_pulse_gen_if
// Purpose  : Raw button levels in; debounced levels and one-shot pulses out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface button_pulse_gen_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] InputPulse;
  logic [CHANNELS-1:0] OneShot;
  logic [CHANNELS-1:0] Held;

  modport master (output InputPulse, input OneShot, input Held);
  modport slave  (input InputPulse, output OneShot, output Held);
endinterface
`default_nettype wire

// File: rtl/button_pulse_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : button_pulse_gen
// Purpose  : Per-channel 2-FF sync, stable-count debounce and one-shot pulse
//            generator; define AUTO_REPEAT_EN to add auto-repeat while held.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module button_pulse_gen #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 1,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input wire                CLOCK,
  input wire                Reset,
  button_pulse_gen_if.slave bus
);

  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PW_W-1:0] c_PW_LAST = c_PW_W'(PULSE_WIDTH - 1);

`ifdef AUTO_REPEAT_EN
  localparam int c_RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RT_W   = (c_RT_MAX > 1) ? $clog2(c_RT_MAX) : 1;
  localparam logic [c_RT_W-1:0] c_RD_LAST = c_RT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RT_W-1:0] c_RP_LAST = c_RT_W'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no effect without auto-repeat.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeatUnused
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  wire [CHANNELS-1:0] w_oneShot;
  wire [CHANNELS-1:0] w_held;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    logic              r_sync1, r_sync2, r_held, r_oneShot, w_oneShotNext;
    logic [c_DB_W-1:0] r_dbCnt;
    logic [c_PW_W-1:0] r_pulseCnt, w_pulseCntNext;
    state_t            r_state, w_stateNext;
    logic              w_mismatch, w_accept, w_rise;
`ifdef AUTO_REPEAT_EN
    logic [c_RT_W-1:0] r_repTimer, w_repTimerNext;
    logic              r_repeated, w_repeatedNext;
`endif

    assign w_mismatch = (r_sync2 != r_held);
    assign w_accept   = w_mismatch && (r_dbCnt == c_DB_LAST);
    // Held rises on this edge, so the pulse can start on the same edge.
    assign w_rise     = w_accept && r_sync2;

    always_ff @(posedge CLOCK) begin
      if (Reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_held  <= 1'b0;
        r_dbCnt <= '0;
      end else begin
        r_sync1 <= bus.InputPulse[i];
        r_sync2 <= r_sync1;
        if (!w_mismatch || w_accept) r_dbCnt <= '0;
        else                         r_dbCnt <= r_dbCnt + 1'b1;
        if (w_accept) r_held <= r_sync2;
      end
    end

    always_ff @(posedge CLOCK) begin
      if (Reset) begin
        r_state    <= S_IDLE;
        r_oneShot  <= 1'b0;
        r_pulseCnt <= '0;
`ifdef AUTO_REPEAT_EN
        r_repTimer <= '0;
        r_repeated <= 1'b0;
`endif
      end else begin
        r_state    <= w_stateNext;
        r_oneShot  <= w_oneShotNext;
        r_pulseCnt <= w_pulseCntNext;
`ifdef AUTO_REPEAT_EN
        r_repTimer <= w_repTimerNext;
        r_repeated <= w_repeatedNext;
`endif
      end
    end

    always_comb begin
      w_stateNext    = r_state;
      w_oneShotNext  = r_oneShot;
      w_pulseCntNext = r_pulseCnt;
`ifdef AUTO_REPEAT_EN
      w_repTimerNext = r_repTimer;
      w_repeatedNext = r_repeated;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_oneShotNext  = 1'b1;
            w_pulseCntNext = '0;
            w_stateNext    = S_FIRE;
`ifdef AUTO_REPEAT_EN
            w_repeatedNext = 1'b0;
`endif
          end
        end
        S_FIRE: begin
          if (r_pulseCnt == c_PW_LAST) begin
            w_oneShotNext = 1'b0;
            w_stateNext   = r_held ? S_HOLD : S_IDLE;
`ifdef AUTO_REPEAT_EN
            w_repTimerNext = '0;
`endif
          end else begin
            w_pulseCntNext = r_pulseCnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!r_held) begin
            w_stateNext = S_IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (r_repTimer == (r_repeated ? c_RP_LAST : c_RD_LAST)) begin
            w_oneShotNext  = 1'b1;
            w_pulseCntNext = '0;
            w_repeatedNext = 1'b1;
            w_stateNext    = S_FIRE;
          end else begin
            w_repTimerNext = r_repTimer + 1'b1;
          end
`endif
        end
        default: w_stateNext = S_IDLE;
      endcase
    end

    assign w_oneShot[i] = r_oneShot;
    assign w_held[i]    = r_held;
  end

  assign bus.OneShot = w_oneShot;
  assign bus.Held    = w_held;

endmodule
`default_nettype wire
